// File: rtl/load_window.sv
// Loads a KxK activation window from a dual-port BRAM, two rows per pass.
// Optional zero padding of masked rows/columns: define LOAD_WINDOW_ZERO_PAD_EN.
module load_window #(
  parameter int KERNEL     = 3,
  parameter int DATA_WIDTH = 8,
  parameter int BRAM_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BRAM_LAT   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH-1:0]                row_pitch,
  input  logic [11:0]                          col_pitch,
  input  logic [KERNEL-1:0]                    row_mask,
  input  logic [KERNEL-1:0]                    col_mask,
  output logic                                 busy,
  output logic                                 done,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  window,
  output logic [ADDR_WIDTH-1:0]                bram_a_addr,
  output logic [ADDR_WIDTH-1:0]                bram_b_addr,
  output logic                                 bram_en,
  output logic                                 bram_wen,
  output logic [BRAM_WIDTH-1:0]                bram_din,
  input  logic [BRAM_WIDTH-1:0]                bram_a_dout,
  input  logic [BRAM_WIDTH-1:0]                bram_b_dout
);

  localparam int PASSES = (KERNEL + 1) / 2;
  localparam int LANES  = BRAM_WIDTH / DATA_WIDTH;
  localparam int LB     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam bit ODD    = (KERNEL % 2) == 1;
  localparam logic [2:0] COL_LAST  = 3'(KERNEL - 1);
  localparam logic [2:0] PASS_LAST = 3'(PASSES - 1);
  localparam logic [1:0] LAT_LAST  = 2'(BRAM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [2:0]            col;
  logic [2:0]            pass;
  logic [1:0]            drain;
  logic [ADDR_WIDTH-1:0] row_a;
  logic [ADDR_WIDTH-1:0] row_b;
  logic [ADDR_WIDTH-1:0] pitch2;
  logic [11:0]           cpitch_q;

  logic                  pv  [BRAM_LAT];
  logic                  pvb [BRAM_LAT];
  logic [2:0]            pp  [BRAM_LAT];
  logic [2:0]            pc  [BRAM_LAT];
  logic [LB-1:0]         pla [BRAM_LAT];
  logic [LB-1:0]         plb [BRAM_LAT];

  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  b_active;

  assign bram_en  = 1'b1;
  assign bram_wen = 1'b0;
  assign bram_din = '0;

  function automatic logic [LB-1:0] lane_of(input logic [ADDR_WIDTH-1:0] a);
    logic [LB-1:0] l;
    l = '0;
    if (LANES > 1) l = a[LB-1:0];
    return l;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [BRAM_WIDTH-1:0] w,
                                                 input logic [LB-1:0] lane);
    logic [DATA_WIDTH-1:0] s;
    s = '0;
    for (int unsigned l = 0; l < LANES; l++)
      if (lane == LB'(l)) s = w[l*DATA_WIDTH +: DATA_WIDTH];
    return s;
  endfunction

`ifdef LOAD_WINDOW_ZERO_PAD_EN
  logic [KERNEL-1:0] rm_q;
  logic [KERNEL-1:0] cm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rm_q <= '0;
      cm_q <= '0;
    end else if (state == IDLE && start) begin
      rm_q <= row_mask;
      cm_q <= col_mask;
    end
  end
`else
  logic unused_masks;
  assign unused_masks = ^{row_mask, col_mask};
`endif

  // Port B sits idle during the last pass when K is odd (no row 2p+1).
  assign b_active = !(ODD && pass == PASS_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      col         <= '0;
      pass        <= '0;
      drain       <= '0;
      bram_a_addr <= '0;
      bram_b_addr <= '0;
      row_a       <= '0;
      row_b       <= '0;
      pitch2      <= '0;
      cpitch_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= ISSUE;
          busy        <= 1'b1;
          col         <= '0;
          pass        <= '0;
          drain       <= '0;
          bram_a_addr <= base_addr;
          row_a       <= base_addr;
          if (KERNEL > 1) begin
            bram_b_addr <= base_addr + row_pitch;
            row_b       <= base_addr + row_pitch;
          end
          pitch2      <= row_pitch + row_pitch;
          cpitch_q    <= col_pitch;
        end
        ISSUE: begin
          if (col != COL_LAST) begin
            col         <= col + 3'd1;
            bram_a_addr <= bram_a_addr + ADDR_WIDTH'(cpitch_q);
            if (b_active) bram_b_addr <= bram_b_addr + ADDR_WIDTH'(cpitch_q);
          end else begin
            col <= '0;
            if (pass == PASS_LAST) begin
              state <= DRAIN;
            end else begin
              pass        <= pass + 3'd1;
              row_a       <= row_a + pitch2;
              bram_a_addr <= row_a + pitch2;
              if (!(ODD && pass == PASS_LAST - 3'd1)) begin
                row_b       <= row_b + pitch2;
                bram_b_addr <= row_b + pitch2;
              end
            end
          end
        end
        DRAIN: begin
          if (drain == LAT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain <= drain + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags travel BRAM_LAT stages so they line up with the returning read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < BRAM_LAT; j++) begin
        pv[j]  <= 1'b0;
        pvb[j] <= 1'b0;
        pp[j]  <= '0;
        pc[j]  <= '0;
        pla[j] <= '0;
        plb[j] <= '0;
      end
    end else begin
      pv[0]  <= state == ISSUE;
      pvb[0] <= state == ISSUE && b_active;
      pp[0]  <= pass;
      pc[0]  <= col;
      pla[0] <= lane_of(bram_a_addr);
      plb[0] <= lane_of(bram_b_addr);
      for (int unsigned j = 1; j < BRAM_LAT; j++) begin
        pv[j]  <= pv[j-1];
        pvb[j] <= pvb[j-1];
        pp[j]  <= pp[j-1];
        pc[j]  <= pc[j-1];
        pla[j] <= pla[j-1];
        plb[j] <= plb[j-1];
      end
    end
  end

  always_comb begin
    data_a = pick(bram_a_dout, pla[BRAM_LAT-1]);
    data_b = pick(bram_b_dout, plb[BRAM_LAT-1]);
  end

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar c = 0; c < KERNEL; c++) begin : g_col
      logic [DATA_WIDTH-1:0] el;
      logic [DATA_WIDTH-1:0] val;
      logic                  hit;

      always_comb begin
        hit = pp[BRAM_LAT-1] == 3'(r / 2) && pc[BRAM_LAT-1] == 3'(c) &&
              (((r % 2) == 0) ? pv[BRAM_LAT-1] : pvb[BRAM_LAT-1]);
        val = ((r % 2) == 0) ? data_a : data_b;
`ifdef LOAD_WINDOW_ZERO_PAD_EN
        if (!(rm_q[r] && cm_q[c])) val = '0;
`endif
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     el <= '0;
        else if (hit) el <= val;
      end

      assign window[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = el;
    end
  end

endmodule

// File: tb/tb_load_window.sv
// Randomized bench for load_window: K=3/LAT=1 and K=5/LAT=2 instances vs a behavioural model.
module tb_load_window;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_start [2];
  logic [31:0] in_base  [2];
  logic [31:0] in_rp    [2];
  logic [11:0] in_cp    [2];
  logic [6:0]  in_rm    [2];
  logic [6:0]  in_cm    [2];

  logic        busy0, done0, busy1, done1;
  logic [71:0]  win0;
  logic [199:0] win1;
  logic [31:0] aa0, ab0, aa1, ab1, da0, db0, da1, db1, p1a, p1b, din0, din1;
  logic        en0, wen0, en1, wen1;

  logic [7:0]  key = 8'h00;
  int          n_chk = 0;
  int          n_pass = 0;

  logic        m_busy [2];
  logic        m_done [2];
  int          m_cnt  [2];
  logic [7:0]  m_win  [2][49];
  logic [31:0] m_base [2];
  logic [31:0] m_rp   [2];
  logic [11:0] m_cp   [2];
  logic [6:0]  m_rm   [2];
  logic [6:0]  m_cm   [2];
  int          mk, ml;
  logic [31:0] maddr;
  logic [7:0]  mv;

  always #5 clk = ~clk;

  load_window u0 (
    .clk(clk), .rst(rst), .start(in_start[0]), .base_addr(in_base[0]),
    .row_pitch(in_rp[0]), .col_pitch(in_cp[0]),
    .row_mask(in_rm[0][2:0]), .col_mask(in_cm[0][2:0]),
    .busy(busy0), .done(done0), .window(win0),
    .bram_a_addr(aa0), .bram_b_addr(ab0), .bram_en(en0), .bram_wen(wen0),
    .bram_din(din0), .bram_a_dout(da0), .bram_b_dout(db0)
  );

  load_window #(.KERNEL(5), .BRAM_LAT(2)) u1 (
    .clk(clk), .rst(rst), .start(in_start[1]), .base_addr(in_base[1]),
    .row_pitch(in_rp[1]), .col_pitch(in_cp[1]),
    .row_mask(in_rm[1][4:0]), .col_mask(in_cm[1][4:0]),
    .busy(busy1), .done(done1), .window(win1),
    .bram_a_addr(aa1), .bram_b_addr(ab1), .bram_en(en1), .bram_wen(wen1),
    .bram_din(din1), .bram_a_dout(da1), .bram_b_dout(db1)
  );

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return a[7:0] ^ key;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {byte_at(w + 32'd3), byte_at(w + 32'd2), byte_at(w + 32'd1), byte_at(w)};
  endfunction

  // BRAM: u0 one-cycle read, u1 two-cycle read
  always @(posedge clk) begin
    da0 <= word_at(aa0);
    db0 <= word_at(ab0);
    p1a <= word_at(aa1);
    p1b <= word_at(ab1);
    da1 <= p1a;
    db1 <= p1b;
  end

  // Reference model: start accepted when idle, done P*K+LAT+1 edges later,
  // window element (r,c) = byte at base + r*row_pitch + c*col_pitch.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_busy[ch] = 1'b0;
        m_done[ch] = 1'b0;
        m_cnt[ch]  = 0;
        for (int i = 0; i < 49; i++) m_win[ch][i] = 8'h00;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        mk = (ch == 1) ? 5 : 3;
        ml = (ch == 1) ? 2 : 1;
        m_done[ch] = 1'b0;
        if (m_busy[ch]) begin
          m_cnt[ch] = m_cnt[ch] - 1;
          if (m_cnt[ch] == 0) begin
            m_busy[ch] = 1'b0;
            m_done[ch] = 1'b1;
            for (int r = 0; r < mk; r++)
              for (int c = 0; c < mk; c++) begin
                maddr = m_base[ch] + 32'(r) * m_rp[ch] + 32'(c) * 32'(m_cp[ch]);
                mv = byte_at(maddr);
`ifdef LOAD_WINDOW_ZERO_PAD_EN
                if (!m_rm[ch][r] || !m_cm[ch][c]) mv = 8'h00;
`endif
                m_win[ch][r*mk+c] = mv;
              end
          end
        end else if (in_start[ch]) begin
          m_base[ch] = in_base[ch];
          m_rp[ch]   = in_rp[ch];
          m_cp[ch]   = in_cp[ch];
          m_rm[ch]   = in_rm[ch];
          m_cm[ch]   = in_cm[ch];
          m_busy[ch] = 1'b1;
          m_cnt[ch]  = ((mk + 1) / 2) * mk + ml + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [391:0] act, input logic [391:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [391:0] exp_vec(input int ch);
    logic [391:0] v;
    int k;
    v = '0;
    k = (ch == 1) ? 5 : 3;
    for (int i = 0; i < k * k; i++) v[i*8 +: 8] = m_win[ch][i];
    return v;
  endfunction

  always @(negedge clk) begin
    chk("busy0", 392'(busy0), 392'(m_busy[0]));
    chk("done0", 392'(done0), 392'(m_done[0]));
    chk("busy1", 392'(busy1), 392'(m_busy[1]));
    chk("done1", 392'(done1), 392'(m_done[1]));
    if (!m_busy[0]) chk("win0", 392'(win0), exp_vec(0));
    if (!m_busy[1]) chk("win1", 392'(win1), exp_vec(1));
  end

  function automatic logic done_of(input int ch);
    return (ch == 1) ? done1 : done0;
  endfunction

  task automatic run_load(input int ch, input logic [31:0] b, input logic [31:0] rp,
                          input logic [11:0] cp, input logic [6:0] rm, input logic [6:0] cm,
                          output int lat);
    logic seen;
    in_base[ch] = b;
    in_rp[ch]   = rp;
    in_cp[ch]   = cp;
    in_rm[ch]   = rm;
    in_cm[ch]   = cm;
    in_start[ch] = 1'b1;
    @(posedge clk);
    #2 in_start[ch] = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      lat++;
      #1;
      seen = done_of(ch);
    end
    if (!seen) chk("done_timeout", 392'(0), 392'(1));
    #1;
  endtask

  initial begin
    int lat;
    int bc;
    for (int ch = 0; ch < 2; ch++) begin
      in_start[ch] = 1'b0;
      in_base[ch]  = '0;
      in_rp[ch]    = '0;
      in_cp[ch]    = '0;
      in_rm[ch]    = 7'h7f;
      in_cm[ch]    = 7'h7f;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_busy", 392'(busy0), 392'(0));
    chk("rst_win", 392'(win0), 392'(0));
    chk("const_en_wen_din", 392'({en0, wen0, din0}), 392'({1'b1, 1'b0, 32'h0}));

    // K=3 reference load
    run_load(0, 32'h100, 32'h40, 12'd1, 7'h7f, 7'h7f, lat);
    chk("lat_k3", 392'(lat), 392'(8));
    chk("el_1_2", 392'(win0[5*8 +: 8]), 392'(8'h42));
    chk("el_2_0", 392'(win0[6*8 +: 8]), 392'(8'h80));

    // lanes across word boundaries
    run_load(0, 32'h101, 32'h40, 12'd3, 7'h7f, 7'h7f, lat);
    chk("el_0_1_lane", 392'(win0[1*8 +: 8]), 392'(8'h04));
    chk("el_2_2_lane", 392'(win0[8*8 +: 8]), 392'(8'h87));

    // start held high: one done per load, busy exactly 8 cycles
    in_base[0] = 32'h300; in_rp[0] = 32'h10; in_cp[0] = 12'd2;
    in_start[0] = 1'b1;
    @(posedge clk);
    #1;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0) break;
      if (busy0) bc++;
      @(posedge clk);
      #1;
    end
    chk("busy_len", 392'(bc), 392'(8));
    repeat (12) @(posedge clk);
    #2 in_start[0] = 1'b0;
    for (int i = 0; i < 40 && busy0; i++) @(posedge clk);
    @(posedge clk);
    #2;

    // reset during ISSUE cycle 3
    in_base[0] = 32'h500; in_rp[0] = 32'h20; in_cp[0] = 12'd1;
    in_start[0] = 1'b1;
    @(posedge clk);
    #2 in_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 392'(busy0), 392'(0));
    chk("midrst_done", 392'(done0), 392'(0));
    chk("midrst_win", 392'(win0), 392'(0));
    chk("midrst_addr", 392'({aa0, ab0}), 392'(0));
    @(posedge clk);
    #2 rst = 1'b1;
    run_load(0, 32'h100, 32'h40, 12'd1, 7'h7f, 7'h7f, lat);
    chk("lat_after_rst", 392'(lat), 392'(8));

    // masked load
    key = 8'h5a;
    run_load(0, 32'h100, 32'h40, 12'd1, 7'b110, 7'b011, lat);
    chk("mask_el_1_1", 392'(win0[4*8 +: 8]), 392'(8'h1b));
`ifdef LOAD_WINDOW_ZERO_PAD_EN
    chk("mask_el_0_0", 392'(win0[0 +: 8]), 392'(8'h00));
    chk("mask_el_1_2", 392'(win0[5*8 +: 8]), 392'(8'h00));
`else
    chk("mask_el_0_0", 392'(win0[0 +: 8]), 392'(8'h5a));
    chk("mask_el_1_2", 392'(win0[5*8 +: 8]), 392'(8'h18));
`endif

    // K=5, LAT=2
    key = 8'h00;
    run_load(1, 32'h200, 32'h20, 12'd2, 7'h7f, 7'h7f, lat);
    chk("lat_k5", 392'(lat), 392'(18));
    chk("k5_el_4_4", 392'(win1[24*8 +: 8]), 392'(8'h88));
    chk("k5_el_3_1", 392'(win1[16*8 +: 8]), 392'(8'h62));

    // random traffic on both instances, inputs churn while busy
    key = 8'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #2;
      for (int ch = 0; ch < 2; ch++) begin
        in_start[ch] = ($urandom_range(0, 3) == 0);
        in_base[ch]  = $urandom;
        in_rp[ch]    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
        in_cp[ch]    = 12'($urandom);
        in_rm[ch]    = 7'($urandom);
        in_cm[ch]    = 7'($urandom);
      end
    end
    in_start[0] = 1'b0;
    in_start[1] = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/load_window.md
LOAD_WINDOW -- requirements
Module: load_window

Interface
REQ-001 Parameter KERNEL, default 3, window edge K (legal 1..7).
REQ-002 Parameter DATA_WIDTH, default 8, bits per activation element.
REQ-003 Parameter BRAM_WIDTH, default 32, BRAM data word bits (multiple of DATA_WIDTH, power of two).
REQ-004 Parameter ADDR_WIDTH, default 32, BRAM byte-address bits.
REQ-005 Parameter BRAM_LAT, default 1, BRAM read latency in cycles (1 or 2).
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 start  input  1  load request; sampled in IDLE only.
REQ-009 base_addr  input  ADDR_WIDTH  byte address of window element (0,0).
REQ-010 row_pitch  input  ADDR_WIDTH  byte distance between window rows.
REQ-011 col_pitch  input  12  byte distance between window columns (= channel count).
REQ-012 row_mask, col_mask  input  K each  bit set = row/column inside image.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse; window valid from this cycle.
REQ-015 window  output  K*K*DATA_WIDTH  element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-016 bram_a_addr, bram_b_addr  output  ADDR_WIDTH  byte read addresses; bram_en=1, bram_wen=0, bram_din=0 constant.
REQ-017 bram_a_dout, bram_b_dout  input  BRAM_WIDTH  read data.

Function
REQ-018 States IDLE, ISSUE, DRAIN; IDLE->ISSUE on start, ISSUE->DRAIN after last issue cycle, DRAIN->IDLE after BRAM_LAT cycles with done pulse.
REQ-019 base_addr, row_pitch, col_pitch, masks SHALL be latched at start acceptance; later changes ignored until next start.
REQ-020 start while busy SHALL be ignored without side effect.
REQ-021 ISSUE runs P=ceil(K/2) passes of K cycles; pass p, cycle c reads row 2p on port A and row 2p+1 on port B, column c.
REQ-022 Address(r,c) = base + r*row_pitch + c*col_pitch, computed incrementally (adders only, no multiplier), modulo 2^ADDR_WIDTH wrap.
REQ-023 Byte lane = address low log2(BRAM_WIDTH/DATA_WIDTH) bits, delayed BRAM_LAT cycles alongside row/column tags to select the captured slice.
REQ-024 For odd K, port B in final pass SHALL hold its last address; its data SHALL NOT be written.
REQ-025 Latency start-accept to done = P*K + BRAM_LAT + 1 cycles (K=3, LAT=1: 8).
REQ-026 window SHALL hold its value from done until the capture phase of the next load; partially updated during a load.
REQ-027 busy SHALL fall in the same cycle done rises; a start in the done cycle's following cycle SHALL be accepted.

Reset
REQ-028 rst low SHALL immediately force IDLE, busy=0, done=0, window=0, addresses=0, pipeline tags cleared, including mid-load.
REQ-029 After rst release, first start accepted on the first rising edge with start=1.

Configuration
REQ-030 Macro LOAD_WINDOW_ZERO_PAD_EN defined: element (r,c) with row_mask[r]=0 or col_mask[c]=0 SHALL be written 0 regardless of BRAM data; timing unchanged.
REQ-031 Macro undefined: masks ignored (ports kept, unconnected internally); all elements taken from BRAM.

Verification
REQ-032 K=3, LAT=1, base=0x100, row_pitch=0x40, col_pitch=1, BRAM byte = addr[7:0] -> done 8 cycles after start; element (1,2)=0x42, (2,0)=0x80.
REQ-033 col_pitch=3, base=0x101 -> lane selection correct across word boundaries; element (0,1)=byte 0x104.
REQ-034 start held high through load -> exactly one done per load; second start accepted only after done; busy=1 for 8 cycles.
REQ-035 rst low at ISSUE cycle 3 -> busy, done, window 0 asynchronously; next load after release completes normally.
REQ-036 ZERO_PAD_EN defined, row_mask=3'b110, col_mask=3'b011 -> row 0 and column 2 all zero, others from BRAM; undefined -> all from BRAM.
REQ-037 K=5, LAT=2 -> port B idle in pass 2, done 3*5+2+1=18 cycles after start, all 25 elements correct.
